// File: rtl/dpe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dpe_pkg : shared types and constants for dot_product_engine        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package dpe_pkg;
  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;

  typedef struct packed {
    logic            valid;
    logic            last;
    logic            relu;
    logic [FP_W-1:0] data;
  } stage_t;

  function automatic int TREE_DEPTH(input int lanes);
    return $clog2(lanes);
  endfunction
endpackage
`default_nettype wire

// File: rtl/dot_product_engine_adder_tree.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fp_adder_tree : pairwise registered adder levels with sideband     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fp_adder_tree import dpe_pkg::*; #(
  parameter int LANES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  adv,
  input  logic                  in_valid,
  input  logic                  in_last,
  input  logic                  in_relu,
  input  logic [LANES*FP_W-1:0] in_data,
  output stage_t                out_stage
);
  localparam int DEPTH = TREE_DEPTH(LANES);

  for (genvar k = 0; k <= DEPTH; k++) begin : g_lvl
    localparam int N = LANES >> k;
    logic [N*FP_W-1:0] data;
    logic              valid, last, relu;

    if (k == 0) begin : g_src
      assign data  = in_data;
      assign valid = in_valid;
      assign last  = in_last;
      assign relu  = in_relu;
    end else begin : g_reg
      logic [N*FP_W-1:0] data_d, data_q;
      logic              valid_q, last_q, relu_q;

      for (genvar j = 0; j < N; j++) begin : g_add
        fp_adder u_add (
          .a (g_lvl[k-1].data[(2*j)*FP_W +: FP_W]),
          .b (g_lvl[k-1].data[(2*j+1)*FP_W +: FP_W]),
          .y (data_d[j*FP_W +: FP_W])
        );
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          relu_q  <= 1'b0;
        end else if (adv) begin
          valid_q <= g_lvl[k-1].valid;
          last_q  <= g_lvl[k-1].last;
          relu_q  <= g_lvl[k-1].relu;
          data_q  <= data_d;
        end
      end

      assign data  = data_q;
      assign valid = valid_q;
      assign last  = last_q;
      assign relu  = relu_q;
    end
  end

  assign out_stage = {g_lvl[DEPTH].valid, g_lvl[DEPTH].last,
                      g_lvl[DEPTH].relu, g_lvl[DEPTH].data};
endmodule
`default_nettype wire

// File: rtl/fp_adder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fp_adder : combinational binary32 add, truncating, FTZ             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fp_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [31:0] big, sml;
  logic [7:0]  diff;
  logic [26:0] m_big, m_sml_raw, m_sml;
  logic [27:0] sum, norm;
  logic [4:0]  msb;
  logic [9:0]  e_res;
  logic [22:0] frac;

  always_comb begin
    if (a[30:0] >= b[30:0]) begin
      big = a; sml = b;
    end else begin
      big = b; sml = a;
    end
    diff      = big[30:23] - sml[30:23];
    m_big     = {big[30:23] != 8'h00, big[22:0], 3'b000};
    m_sml_raw = {sml[30:23] != 8'h00, sml[22:0], 3'b000};
    m_sml     = (diff > 8'd26) ? 27'd0 : (m_sml_raw >> diff);
    sum = (big[31] == sml[31]) ? ({1'b0, m_big} + {1'b0, m_sml})
                               : ({1'b0, m_big} - {1'b0, m_sml});
    msb = 5'd0;
    for (int i = 0; i < 28; i++)
      if (sum[i]) msb = 5'(i);
    // hidden bit sits at position 26 after normalisation
    norm  = (msb >= 5'd26) ? (sum >> (msb - 5'd26)) : (sum << (5'd26 - msb));
    frac  = 23'(norm >> 3);
    e_res = 10'(big[30:23]) + 10'(msb) - 10'd26;
    if ((&big[30:23]) && (big[22:0] != 23'h0))
      y = 32'h7FC0_0000;
    else if (&big[30:23])
      y = ((&sml[30:23]) && (sml[31] != big[31])) ? 32'h7FC0_0000 : big;
    else if (sum == 28'd0)
      y = 32'h0;
    else if (e_res[9] || (e_res == 10'd0))
      y = {big[31], 31'h0};
    else if (e_res >= 10'd255)
      y = {big[31], 8'hFF, 23'h0};
    else
      y = {big[31], e_res[7:0], frac};
  end
endmodule
`default_nettype wire

// File: rtl/fp_multiplier.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fp_multiplier : combinational binary32 multiply, truncating, FTZ   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fp_multiplier (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic        sign, a_inf, b_inf, a_nan, b_nan, a_zero, b_zero;
  logic [47:0] prod;
  logic [24:0] top;
  logic [9:0]  exp_r;
  logic [22:0] frac;

  always_comb begin
    sign   = a[31] ^ b[31];
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    a_inf  = (&a[30:23]) && (a[22:0] == 23'h0);
    b_inf  = (&b[30:23]) && (b[22:0] == 23'h0);
    a_nan  = (&a[30:23]) && (a[22:0] != 23'h0);
    b_nan  = (&b[30:23]) && (b[22:0] != 23'h0);
    prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    top    = 25'(prod >> 23);
    exp_r  = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127 + (top[24] ? 10'd1 : 10'd0);
    frac   = top[24] ? top[23:1] : top[22:0];
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      y = 32'h7FC0_0000;
    else if (a_inf || b_inf)
      y = {sign, 8'hFF, 23'h0};
    else if (a_zero || b_zero || exp_r[9] || (exp_r == 10'd0))
      y = {sign, 31'h0};
    else if (exp_r >= 10'd255)
      y = {sign, 8'hFF, 23'h0};
    else
      y = {sign, exp_r[7:0], frac};
  end
endmodule
`default_nettype wire

// File: rtl/dot_product_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | dot_product_engine : pipelined binary32 dot product with ReLU      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module dot_product_engine #(
  parameter int LANES = 8,
  parameter int FP_W  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*FP_W-1:0] in_a,
  input  logic [LANES*FP_W-1:0] in_b,
  input  logic                  in_last,
  input  logic                  relu_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FP_W-1:0]       result
);
  import dpe_pkg::*;

  logic                  adv;
  logic [LANES*FP_W-1:0] prod_d, mul_data_q;
  logic                  mul_valid_q, mul_last_q, mul_relu_q;
  stage_t                tree_out;
  logic [FP_W-1:0]       acc_q, acc_d, acc_sum, res_q, res_d, sum_relu;
  logic                  out_valid_q, out_valid_d;

  // the whole pipeline freezes only while a finished result is refused
  assign adv      = !(out_valid_q && !out_ready);
  assign in_ready = adv;

  for (genvar i = 0; i < LANES; i++) begin : g_mul
    fp_multiplier u_mul (
      .a (in_a[i*FP_W +: FP_W]),
      .b (in_b[i*FP_W +: FP_W]),
      .y (prod_d[i*FP_W +: FP_W])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mul_valid_q <= 1'b0;
      mul_last_q  <= 1'b0;
      mul_relu_q  <= 1'b0;
      mul_data_q  <= '0;
    end else if (adv) begin
      mul_valid_q <= in_valid;
      mul_last_q  <= in_last;
      mul_relu_q  <= relu_en && in_last;
      mul_data_q  <= prod_d;
    end
  end

  fp_adder_tree #(.LANES(LANES)) u_tree (
    .clk       (clk),
    .reset     (reset),
    .adv       (adv),
    .in_valid  (mul_valid_q),
    .in_last   (mul_last_q),
    .in_relu   (mul_relu_q),
    .in_data   (mul_data_q),
    .out_stage (tree_out)
  );

  fp_adder u_acc (.a(acc_q), .b(tree_out.data), .y(acc_sum));

  always_comb begin
    acc_d       = acc_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    // sign-bit test also zeroes -0.0 and negative NaN
    sum_relu    = (tree_out.relu && acc_sum[FP_W-1]) ? FP_POS_ZERO : acc_sum;
    if (adv) begin
      out_valid_d = tree_out.valid && tree_out.last;
      if (tree_out.valid) begin
        if (tree_out.last) begin
          res_d = sum_relu;
          acc_d = FP_POS_ZERO;
        end else begin
          acc_d = acc_sum;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= FP_POS_ZERO;
      res_q       <= FP_POS_ZERO;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = res_q;
endmodule
`default_nettype wire

// File: tb/tb_dot_product_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_dot_product_engine : directed + random bench, integer-exact ref |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_dot_product_engine;
  localparam int LANES = 8;
  localparam int W     = LANES * 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_last = 1'b0;
  logic         relu_en = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  result;

  int          checks = 0;
  int          errors = 0;
  int          hold_cnt = 0;
  bit          rand_ready = 1'b0;
  bit          saw_stall = 1'b0;
  int          hold_viol = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_result = '0;
  logic [31:0] got[$];
  logic [31:0] exp_q[$];

  dot_product_engine #(.LANES(LANES), .FP_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .relu_en   (relu_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  // Collect delivered results and watch that a refused result is held.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && !(out_valid === 1'b1 && result === prev_result))
        hold_viol <= hold_viol + 1;
      if (out_valid && out_ready) got.push_back(result);
      prev_stall  <= out_valid && !out_ready;
      prev_result <= result;
    end
  end

  function automatic logic [31:0] int_to_fp(input int v);
    int          mag, msb;
    logic [31:0] m;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? -v : v;
    msb = 0;
    for (int i = 0; i < 24; i++)
      if ((mag >> i) != 0) msb = i;
    m = mag;
    return {(v < 0) ? 1'b1 : 1'b0, 8'(127 + msb), 23'((m << (23 - msb)) & 32'h007F_FFFF)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (hold_cnt > 0) hold_cnt--;
    out_ready = (hold_cnt == 0) && (rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1);
  endtask

  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic last, input logic relu);
    int   guard;
    logic acc;
    guard = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last; relu_en = relu;
    forever begin
      @(negedge clk);
      acc = in_ready;
      if (!acc) saw_stall = 1'b1;
      tick();
      if (acc) break;
      guard++;
      if (guard > 300) begin
        chk("accept_timeout", 32'(guard), 32'd0);
        break;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic rand_beat(output logic [W-1:0] a, output logic [W-1:0] b, output int dot);
    dot = 0;
    for (int l = 0; l < LANES; l++) begin
      int x, y;
      x = int'($urandom_range(1, 4));
      y = int'($urandom_range(1, 4));
      if ($urandom_range(0, 1) == 1) x = -x;
      if ($urandom_range(0, 1) == 1) y = -y;
      a[l*32 +: 32] = int_to_fp(x);
      b[l*32 +: 32] = int_to_fp(y);
      dot += x * y;
    end
  endtask

  task automatic drain_and_compare(input string tag);
    int guard;
    guard = 0;
    while (got.size() < exp_q.size() && guard < 300) begin
      tick();
      guard++;
    end
    repeat (10) tick();
    chk($sformatf("%s_count", tag), 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_result%0d", tag, i), got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  logic [W-1:0] ones, twos, negs, ra, rb;
  int           n, d, tot, nb;
  logic         rl, rb_relu;

  initial begin
    for (int l = 0; l < LANES; l++) begin
      ones[l*32 +: 32] = 32'h3F80_0000;
      twos[l*32 +: 32] = 32'h4000_0000;
      negs[l*32 +: 32] = 32'hBF80_0000;
    end

    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {31'h0, out_valid}, 32'd0);
    chk("reset_result", result, 32'h0);
    chk("reset_in_ready", {31'h0, in_ready}, 32'd1);
    tick();

    // single beat 1.0 x 2.0: value and latency
    send_beat(ones, twos, 1'b1, 1'b0);
    n = 1;
    while (n < 20) begin
      @(negedge clk);
      if (out_valid) break;
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'd5);
    exp_q.push_back(32'h4180_0000);
    drain_and_compare("single");

    // three-beat vector then single-beat vector back to back
    send_beat(ones, twos, 1'b0, 1'b0);
    send_beat(ones, twos, 1'b0, 1'b0);
    send_beat(ones, twos, 1'b1, 1'b0);
    send_beat(ones, twos, 1'b1, 1'b0);
    exp_q.push_back(32'h4240_0000);
    exp_q.push_back(32'h4180_0000);
    drain_and_compare("multi");

    // negative sum with and without ReLU
    send_beat(negs, ones, 1'b1, 1'b0);
    send_beat(negs, ones, 1'b1, 1'b1);
    exp_q.push_back(32'hC100_0000);
    exp_q.push_back(32'h0000_0000);
    drain_and_compare("relu");

    // consumer stalls for 10 cycles while four vectors are offered
    saw_stall = 1'b0;
    hold_cnt  = 10;
    out_ready = 1'b0;
    for (int v = 0; v < 4; v++) begin
      send_beat(v[0] ? negs : ones, twos, 1'b1, 1'b0);
      exp_q.push_back(v[0] ? 32'hC180_0000 : 32'h4180_0000);
      tick();
      tick();
    end
    chk("in_ready_drop", {31'h0, saw_stall}, 32'd1);
    drain_and_compare("stall");

    // reset in the middle of a vector
    send_beat(ones, twos, 1'b0, 1'b0);
    send_beat(ones, twos, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    send_beat(ones, twos, 1'b1, 1'b0);
    exp_q.push_back(32'h4180_0000);
    drain_and_compare("reset_mid_vector");

    // reset while a finished result is being refused
    hold_cnt  = 30;
    out_ready = 1'b0;
    send_beat(ones, twos, 1'b1, 1'b0);
    repeat (8) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_mid_stall_valid", {31'h0, out_valid}, 32'd0);
    hold_cnt = 0;
    drain_and_compare("reset_mid_stall");

    // five-beat vector with random input bubbles
    for (int bt = 0; bt < 5; bt++) begin
      if ($urandom_range(0, 1) == 1) tick();
      send_beat(ones, twos, bt == 4, 1'b0);
    end
    exp_q.push_back(32'h42A0_0000);
    drain_and_compare("bubbles");

    // random vectors, random bubbles, random consumer back-pressure
    rand_ready = 1'b1;
    for (int v = 0; v < 25; v++) begin
      nb  = int'($urandom_range(1, 4));
      tot = 0;
      rl  = 1'b0;
      for (int bt = 0; bt < nb; bt++) begin
        rand_beat(ra, rb, d);
        tot += d;
        rb_relu = ($urandom_range(0, 1) == 1);
        if (bt == nb - 1) rl = rb_relu;
        if ($urandom_range(0, 1) == 1) tick();
        send_beat(ra, rb, bt == nb - 1, rb_relu);
      end
      exp_q.push_back((rl && tot < 0) ? 32'h0 : int_to_fp(tot));
    end
    rand_ready = 1'b0;
    drain_and_compare("random");

    chk("hold_stable", 32'(hold_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dot_product_engine.md
DOT_PRODUCT_ENGINE -- requirements
Module: dot_product_engine

Interface
REQ-001 Parameter LANES, default 8, multiply lanes per beat; legal values 2, 4, 8, 16.
REQ-002 Parameter FP_W, default 32, IEEE-754 single-precision word width; only 32 is legal.
REQ-003 Clocking and reset: single clock clk; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  beat present on in_a/in_b.
REQ-007 in_ready  output  1  beat accepted when in_valid && in_ready.
REQ-008 in_a  input  LANES*FP_W  packed operand vector; lane i is bits [i*FP_W +: FP_W].
REQ-009 in_b  input  LANES*FP_W  packed operand vector, same lane layout as in_a.
REQ-010 in_last  input  1  accepted beat is the final beat of the current dot product.
REQ-011 relu_en  input  1  apply ReLU to the result; sampled only on the in_last beat.
REQ-012 out_valid  output  1  result holds a completed dot product.
REQ-013 out_ready  input  1  consumer accepts result when out_valid && out_ready.
REQ-014 result  output  FP_W  completed dot product.

Function
REQ-015 Pipeline order: multiply stage (LANES fp_multiplier, registered), then L = log2(LANES) registered adder-tree levels, then accumulate stage, then output register.
REQ-016 Every stage register carries a valid bit, a last bit and a relu bit; bubbles (valid = 0) never modify the accumulator.
REQ-017 Global advance: adv = !(out_valid && !out_ready); all stage registers and the accumulator update only when adv = 1.
REQ-018 in_ready = adv; in_ready is combinational on out_valid/out_ready and independent of in_valid.
REQ-019 Accumulator acc resets to +0.0 (0x00000000).
REQ-020 Valid non-last tree output: acc <= acc + tree_sum.
REQ-021 Valid last tree output: output register <= acc + tree_sum; acc <= +0.0 in the same cycle, so back-to-back vectors never mix.
REQ-022 ReLU applies when the carried relu bit is 1 and the sign bit of the sum is 1: result = 0x00000000 (covers -0.0 and negative NaN). Otherwise result passes unchanged.
REQ-023 Latency: last beat accepted at cycle t gives out_valid = 1 at t + L + 2 when unstalled (LANES = 8: t + 5).
REQ-024 out_valid stays high and result stays stable until the out_ready handshake completes.
REQ-025 Handshake and new result in the same cycle: the output register reloads and out_valid stays 1.
REQ-026 Single-beat vector (in_last on first beat): result = sum of LANES products.
REQ-027 Throughput is one beat per cycle while out_ready = 1; no combinational path from in_valid to out_valid.
REQ-028 FP rounding, NaN and Inf behaviour is that of fp_multiplier/fp_adder; the block adds none of its own.

Reset
REQ-029 Reset clears all stage valid bits, out_valid and the relu/last bits, sets acc = 0x00000000 and result = 0x00000000; in_ready = 1 in the first cycle after reset.
REQ-030 Reset mid-vector or mid-stall discards all partial sums and pending results; no result is emitted for the interrupted vector.

Structure
REQ-031 Shared package dpe_pkg holds FP_W, FP_POS_ZERO (32'h0000_0000), the stage-register struct type {valid, last, relu, data}, and a clog2-based TREE_DEPTH function.
REQ-032 One sub-module fp_adder_tree (parameter LANES): generate-built, pairwise, registered fp_adder levels that carry the valid/last/relu sideband and take adv as enable.
REQ-033 Existing fp_multiplier and fp_adder cores are instantiated unchanged.

Verification
REQ-034 LANES=8; a = 1.0 (0x3F800000), b = 2.0 (0x40000000) all lanes; single last beat at t -> result 0x41800000 (16.0), out_valid at t+5.
REQ-035 Same operands, three beats (last on the third), then a second single-beat vector immediately after -> results 0x42400000 (48.0) then 0x41800000; no carry-over between vectors.
REQ-036 a = -1.0 (0xBF800000), b = 1.0 all lanes, single beat: relu_en = 0 -> 0xC1000000; relu_en = 1 -> 0x00000000.
REQ-037 out_ready held low 10 cycles while four single-beat vectors are offered -> in_ready drops, all four results delivered in order, none lost or duplicated.
REQ-038 Two non-last beats accepted, reset asserted 1 cycle, then one last beat of 1.0 x 2.0 -> only 0x41800000 emitted.
REQ-039 Random in_valid bubbles (50 %) across a 5-beat vector -> result equals the bubble-free result (80.0 = 0x42A00000).
